// File: rtl/mcs4_pkg.sv
// rtl/mcs4_pkg.sv - shared command/state encodings and helpers for the i4002-style RAM bank
package mcs4_pkg;

  typedef enum logic [2:0] {
    OP_NOP = 3'd0,
    OP_SRC = 3'd1,
    OP_WRM = 3'd2,
    OP_RDM = 3'd3,
    OP_WRS = 3'd4,
    OP_RDS = 3'd5
  } cmd_op_e;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } ctrl_state_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_OUT  = 2'd2
  } scan_state_e;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/mcs4_ram_dp.sv
// rtl/mcs4_ram_dp.sv - distributed RAM, one sync write port and two combinational read ports
module mcs4_ram_dp #(
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 128,
  parameter int AW         = 7
) (
  input  logic                  sysclk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr_a,
  output logic [DATA_WIDTH-1:0] rdata_a,
  input  logic [AW-1:0]         raddr_b,
  output logic [DATA_WIDTH-1:0] rdata_b
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // No reset on the array: the bank's clear sweep defines the contents.
  always_ff @(posedge sysclk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Reads see the pre-write value in the cycle a write commits.
  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/mcs4_ram_bank.sv
// rtl/mcs4_ram_bank.sv - i4002-style RAM bank with CPU command port and display scan stream
module mcs4_ram_bank
  import mcs4_pkg::*;
#(
  parameter int DATA_WIDTH   = 4,
  parameter int NUM_REGS     = 4,
  parameter int MAIN_CHARS   = 16,
  parameter int STATUS_CHARS = 4,
  localparam int RA  = (clog2(NUM_REGS) > 1) ? clog2(NUM_REGS) : 1,
  localparam int CA  = (clog2(MAIN_CHARS) > 1) ? clog2(MAIN_CHARS) : 1,
  localparam int SA  = (clog2(STATUS_CHARS) > 1) ? clog2(STATUS_CHARS) : 1,
  localparam int WA  = clog2(MAIN_CHARS + STATUS_CHARS),
  localparam int WPR = 2 ** WA
) (
  input  logic                  sysclk,
  input  logic                  poc,
  output logic                  busy,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [RA-1:0]         cmd_reg,
  input  logic [CA-1:0]         cmd_char,
  input  logic [SA-1:0]         cmd_sidx,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  scan_start,
  input  logic [RA-1:0]         scan_reg,
  output logic                  scan_valid,
  input  logic                  scan_ready,
  output logic [DATA_WIDTH-1:0] scan_data,
  output logic [WA-1:0]         scan_idx,
  output logic                  scan_last
);

  localparam int AW    = RA + WA;
  localparam int DEPTH = NUM_REGS * WPR;
  localparam logic [WA-1:0] LAST_WORD = WA'(MAIN_CHARS + STATUS_CHARS - 1);
  localparam logic [WA-1:0] MAIN_BASE = WA'(MAIN_CHARS);
  localparam logic [RA-1:0] LAST_REG  = RA'(NUM_REGS - 1);

  ctrl_state_e           ctrl_state;
  scan_state_e           scan_state;
  logic [RA-1:0]         clr_reg;
  logic [WA-1:0]         clr_word;
  logic [RA-1:0]         reg_q;
  logic [CA-1:0]         char_q;
  logic [RA-1:0]         scan_reg_q;

  logic                  reg_ok, char_ok, sidx_ok, scan_reg_ok;
  logic                  is_status, tgt_ok, accept, cmd_we;
  logic [WA-1:0]         cmd_word;
  logic [AW-1:0]         cmd_addr, waddr, scan_addr;
  logic                  we;
  logic [DATA_WIDTH-1:0] wdata, rdata_a, rdata_b;

  // Range checks collapse to constants when a field exactly fills its select width.
  if (NUM_REGS == (1 << RA)) begin : g_reg_full
    assign reg_ok      = 1'b1;
    assign scan_reg_ok = 1'b1;
  end else begin : g_reg_part
    assign reg_ok      = (reg_q < RA'(NUM_REGS));
    assign scan_reg_ok = (scan_reg_q < RA'(NUM_REGS));
  end

  if (MAIN_CHARS == (1 << CA)) begin : g_char_full
    assign char_ok = 1'b1;
  end else begin : g_char_part
    assign char_ok = (char_q < CA'(MAIN_CHARS));
  end

  if (STATUS_CHARS == (1 << SA)) begin : g_sidx_full
    assign sidx_ok = 1'b1;
  end else begin : g_sidx_part
    assign sidx_ok = (cmd_sidx < SA'(STATUS_CHARS));
  end

  assign busy      = (ctrl_state == CLEAR);
  assign cmd_ready = (ctrl_state == IDLE);
  assign accept    = cmd_valid & cmd_ready;

  assign is_status = (cmd_op == OP_WRS) || (cmd_op == OP_RDS);
  assign cmd_word  = is_status ? (MAIN_BASE + WA'(cmd_sidx)) : WA'(char_q);
  assign cmd_addr  = {reg_q, cmd_word};
  assign tgt_ok    = reg_ok & (is_status ? sidx_ok : char_ok);
  assign cmd_we    = accept & ((cmd_op == OP_WRM) || (cmd_op == OP_WRS)) & tgt_ok;

  // The clear sweep owns the write port while busy; commands are blocked then anyway.
  assign we        = busy | cmd_we;
  assign waddr     = busy ? {clr_reg, clr_word} : cmd_addr;
  assign wdata     = busy ? '0 : cmd_data;
  assign scan_addr = {scan_reg_q, scan_idx};

  mcs4_ram_dp #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_ram (
    .sysclk  (sysclk),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_a (cmd_addr),
    .rdata_a (rdata_a),
    .raddr_b (scan_addr),
    .rdata_b (rdata_b)
  );

  // Control FSM: post-reset clear sweep, then SRC latch and registered command reads.
  always_ff @(posedge sysclk or posedge poc) begin
    if (poc) begin
      ctrl_state <= CLEAR;
      clr_reg    <= '0;
      clr_word   <= '0;
      reg_q      <= '0;
      char_q     <= '0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
    end else begin
      rd_valid <= 1'b0;
      case (ctrl_state)
        CLEAR: begin
          if (clr_word == LAST_WORD) begin
            clr_word <= '0;
            if (clr_reg == LAST_REG) begin
              clr_reg    <= '0;
              ctrl_state <= IDLE;
            end else begin
              clr_reg <= clr_reg + RA'(1);
            end
          end else begin
            clr_word <= clr_word + WA'(1);
          end
        end
        IDLE: begin
          if (cmd_valid) begin
            case (cmd_op)
              OP_SRC: begin
                reg_q  <= cmd_reg;
                char_q <= cmd_char;
              end
              OP_RDM, OP_RDS: begin
                rd_valid <= 1'b1;
                rd_data  <= tgt_ok ? rdata_a : '0;
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  // Scan FSM: one word per load/out pair, holding the word until the consumer takes it.
  always_ff @(posedge sysclk or posedge poc) begin
    if (poc) begin
      scan_state <= S_IDLE;
      scan_reg_q <= '0;
      scan_idx   <= '0;
      scan_data  <= '0;
      scan_valid <= 1'b0;
      scan_last  <= 1'b0;
    end else begin
      case (scan_state)
        S_IDLE: begin
          if (scan_start && !busy) begin
            scan_reg_q <= scan_reg;
            scan_idx   <= '0;
            scan_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          scan_data  <= scan_reg_ok ? rdata_b : '0;
          scan_valid <= 1'b1;
          scan_last  <= (scan_idx == LAST_WORD);
          scan_state <= S_OUT;
        end
        S_OUT: begin
          if (scan_ready) begin
            scan_valid <= 1'b0;
            scan_last  <= 1'b0;
            if (scan_last) begin
              scan_state <= S_IDLE;
            end else begin
              scan_idx   <= scan_idx + WA'(1);
              scan_state <= S_LOAD;
            end
          end
        end
        default: scan_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcs4_ram_bank.sv
// tb/tb_mcs4_ram_bank.sv - directed self-checking bench for mcs4_ram_bank
module tb_mcs4_ram_bank;
  import mcs4_pkg::*;

  logic       sysclk = 1'b0;
  logic       poc;
  logic       busy;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [1:0] cmd_reg;
  logic [3:0] cmd_char;
  logic [1:0] cmd_sidx;
  logic [3:0] cmd_data;
  logic       rd_valid;
  logic [3:0] rd_data;
  logic       scan_start;
  logic [1:0] scan_reg;
  logic       scan_valid;
  logic       scan_ready;
  logic [3:0] scan_data;
  logic [4:0] scan_idx;
  logic       scan_last;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 sysclk = ~sysclk;

  mcs4_ram_bank dut (
    .sysclk     (sysclk),
    .poc        (poc),
    .busy       (busy),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_reg    (cmd_reg),
    .cmd_char   (cmd_char),
    .cmd_sidx   (cmd_sidx),
    .cmd_data   (cmd_data),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .scan_start (scan_start),
    .scan_reg   (scan_reg),
    .scan_valid (scan_valid),
    .scan_ready (scan_ready),
    .scan_data  (scan_data),
    .scan_idx   (scan_idx),
    .scan_last  (scan_last)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Drive one command for one cycle; called at a negedge, returns at the next negedge.
  task automatic cmd(input logic [2:0] op, input logic [1:0] r, input logic [3:0] c,
                     input logic [1:0] s, input logic [3:0] d);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_reg   = r;
    cmd_char  = c;
    cmd_sidx  = s;
    cmd_data  = d;
    @(negedge sysclk);
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
  endtask

  task automatic src(input logic [1:0] r, input logic [3:0] c);
    cmd(OP_SRC, r, c, 2'd0, 4'd0);
  endtask

  task automatic read_chk(input string tag, input logic [2:0] op, input logic [1:0] s,
                          input logic [3:0] exp);
    cmd(op, 2'd0, 4'd0, s, 4'd0);
    check({tag, "_valid"}, 32'(rd_valid), 32'd1);
    check(tag, 32'(rd_data), 32'(exp));
  endtask

  // Release poc and time the clear sweep; called at a negedge with poc high.
  task automatic release_sweep(input string tag);
    int   cnt = 0;
    logic rdy_seen = 1'b0;
    logic sv_seen  = 1'b0;
    poc = 1'b0;
    while (busy && cnt < 500) begin
      cnt++;
      rdy_seen |= cmd_ready;
      sv_seen  |= scan_valid;
      @(negedge sysclk);
    end
    check({tag, "_busy_cycles"}, 32'(cnt), 32'd80);
    check({tag, "_ready_in_clear"}, 32'(rdy_seen), 32'd0);
    check({tag, "_scan_in_clear"}, 32'(sv_seen), 32'd0);
    check({tag, "_ready_after"}, 32'(cmd_ready), 32'd1);
  endtask

  function automatic logic [3:0] scan_exp(input int w);
    return (w < 16) ? 4'(w) : 4'(w - 15);
  endfunction

  initial begin
    int          words;
    logic        stalled;
    logic        rdy;
    logic [10:0] held;
    int          extra;
    logic        done;
    logic        hit;

    poc        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_op     = OP_NOP;
    cmd_reg    = '0;
    cmd_char   = '0;
    cmd_sidx   = '0;
    cmd_data   = '0;
    scan_start = 1'b0;
    scan_reg   = '0;
    scan_ready = 1'b0;
    repeat (3) @(negedge sysclk);

    check("rst_busy", 32'(busy), 32'd1);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_scan_valid", 32'(scan_valid), 32'd0);
    check("rst_scan_data", 32'(scan_data), 32'd0);
    check("rst_scan_idx", 32'(scan_idx), 32'd0);
    check("rst_scan_last", 32'(scan_last), 32'd0);

    release_sweep("por");

    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 16; c++) begin
        src(2'(r), 4'(c));
        cmd(OP_RDM, 2'd0, 4'd0, 2'd0, 4'd0);
        check($sformatf("clr_main_r%0d_c%0d", r, c), 32'(rd_data), 32'd0);
      end
      for (int s = 0; s < 4; s++) begin
        cmd(OP_RDS, 2'd0, 4'd0, 2'(s), 4'd0);
        check($sformatf("clr_stat_r%0d_s%0d", r, s), 32'(rd_data), 32'd0);
      end
    end

    src(2'd2, 4'd5);
    cmd(OP_WRM, 2'd0, 4'd0, 2'd0, 4'hA);
    read_chk("rdm_r2_c5", OP_RDM, 2'd0, 4'hA);
    cmd(OP_NOP, 2'd0, 4'd0, 2'd0, 4'd0);
    check("rd_valid_one_cycle", 32'(rd_valid), 32'd0);
    src(2'd2, 4'd6);
    read_chk("rdm_r2_c6", OP_RDM, 2'd0, 4'h0);

    src(2'd2, 4'd5);
    read_chk("b2b_rdm", OP_RDM, 2'd0, 4'hA);
    read_chk("b2b_rds", OP_RDS, 2'd0, 4'h0);

    src(2'd3, 4'd0);
    cmd(OP_WRS, 2'd0, 4'd0, 2'd3, 4'h7);
    read_chk("rds_r3_s3", OP_RDS, 2'd3, 4'h7);
    src(2'd3, 4'd3);
    read_chk("rdm_r3_c3", OP_RDM, 2'd0, 4'h0);
    src(2'd2, 4'd0);
    read_chk("rds_r2_s3", OP_RDS, 2'd3, 4'h0);

    for (int c = 0; c < 16; c++) begin
      src(2'd1, 4'(c));
      cmd(OP_WRM, 2'd0, 4'd0, 2'd0, 4'(c));
    end
    for (int s = 0; s < 4; s++) begin
      cmd(OP_WRS, 2'd0, 4'd0, 2'(s), 4'(s + 1));
    end
    src(2'd1, 4'd9);
    read_chk("rdm_r1_c9", OP_RDM, 2'd0, 4'h9);

    scan_reg   = 2'd1;
    scan_start = 1'b1;
    @(negedge sysclk);
    scan_start = 1'b0;
    words   = 0;
    stalled = 1'b0;
    held    = '0;
    for (int cyc = 0; cyc < 400 && words < 20; cyc++) begin
      if (stalled) check("scan_hold", 32'({scan_valid, scan_last, scan_idx, scan_data}), 32'(held));
      rdy        = 1'($urandom_range(0, 1));
      scan_ready = rdy;
      if (scan_valid) begin
        if (rdy) begin
          check("scan_idx", 32'(scan_idx), 32'(words));
          check("scan_data", 32'(scan_data), 32'(scan_exp(words)));
          check("scan_last", 32'(scan_last), 32'(words == 19));
          words++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = {scan_valid, scan_last, scan_idx, scan_data};
        end
      end
      @(negedge sysclk);
    end
    check("scan_words", 32'(words), 32'd20);
    scan_ready = 1'b1;
    extra = 0;
    repeat (6) begin
      @(negedge sysclk);
      if (scan_valid) extra++;
    end
    check("scan_no_extra", 32'(extra), 32'd0);

    src(2'd1, 4'd0);
    scan_ready = 1'b0;
    scan_reg   = 2'd1;
    scan_start = 1'b1;
    @(negedge sysclk);
    scan_start = 1'b0;
    cmd(OP_WRM, 2'd0, 4'd0, 2'd0, 4'hF);
    check("coll_scan_valid", 32'(scan_valid), 32'd1);
    check("coll_scan_idx", 32'(scan_idx), 32'd0);
    check("coll_scan_old", 32'(scan_data), 32'd0);
    scan_ready = 1'b1;
    done = 1'b0;
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      if (scan_valid && scan_last) done = 1'b1;
      @(negedge sysclk);
    end
    scan_ready = 1'b0;
    check("coll_drain", 32'(done), 32'd1);
    read_chk("coll_rdm_new", OP_RDM, 2'd0, 4'hF);

    scan_ready = 1'b1;
    scan_reg   = 2'd1;
    scan_start = 1'b1;
    @(negedge sysclk);
    scan_start = 1'b0;
    hit = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (scan_valid && scan_idx == 5'd7) begin
        hit = 1'b1;
        break;
      end
      @(negedge sysclk);
    end
    check("mid_reach_word7", 32'(hit), 32'd1);
    poc = 1'b1;
    #1;
    check("mid_scan_valid", 32'(scan_valid), 32'd0);
    check("mid_busy", 32'(busy), 32'd1);
    check("mid_cmd_ready", 32'(cmd_ready), 32'd0);
    check("mid_scan_idx", 32'(scan_idx), 32'd0);
    @(negedge sysclk);
    release_sweep("mid");
    extra = 0;
    repeat (20) begin
      @(negedge sysclk);
      if (scan_valid) extra++;
    end
    check("mid_no_more_words", 32'(extra), 32'd0);
    scan_ready = 1'b0;

    src(2'd1, 4'd5);
    read_chk("mid_clr_r1_c5", OP_RDM, 2'd0, 4'h0);
    read_chk("mid_clr_r1_s3", OP_RDS, 2'd3, 4'h0);
    src(2'd2, 4'd5);
    read_chk("mid_clr_r2_c5", OP_RDM, 2'd0, 4'h0);
    src(2'd3, 4'd0);
    read_chk("mid_clr_r3_s3", OP_RDS, 2'd3, 4'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mcs4_ram_bank.md
# mcs4_ram_bank

Parametrised i4002-style RAM bank holding NUM_REGS registers, each with MAIN_CHARS main characters and STATUS_CHARS status characters of DATA_WIDTH bits. Sits between the i4002 bus decoder and the display/VFD driver. The CPU side gets an MCS-4 style command port: SRC address latch, main and status read/write, and registered read data. The display side gets a streaming scan port with valid/ready backpressure. After every reset the bank clears its storage in hardware, so contents are never undefined.

## Interface
- DATA_WIDTH, 4, bits per character
- NUM_REGS, 4, registers in the bank (≥1)
- MAIN_CHARS, 16, main characters per register (≥1)
- STATUS_CHARS, 4, status characters per register (≥1)
- Derived, not overridable:
  - RA = max(1, clog2(NUM_REGS))
  - CA = max(1, clog2(MAIN_CHARS))
  - SA = max(1, clog2(STATUS_CHARS))
  - WA = clog2(MAIN_CHARS+STATUS_CHARS)
  - WPR = 2**WA
- sysclk  in  1  sole clock, all state on rising edge
- poc  in  1  reset. One clock; reset is asynchronous and active-high.
- busy  out  1  high while the post-reset clear sweep runs
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_op  in  3  0 NOP, 1 SRC, 2 WRM, 3 RDM, 4 WRS, 5 RDS; 6–7 treated as NOP
- cmd_reg  in  RA  register select, used by SRC
- cmd_char  in  CA  main-character select, used by SRC
- cmd_sidx  in  SA  status index, used by WRS/RDS
- cmd_data  in  DATA_WIDTH  write data
- rd_valid  out  1  one-cycle pulse, read data valid
- rd_data  out  DATA_WIDTH  registered read data
- scan_start  in  1  request a scan of register scan_reg
- scan_reg  in  RA  register to scan, sampled with scan_start
- scan_valid  out  1  scan word present
- scan_ready  in  1  consumer accepts the word
- scan_data  out  DATA_WIDTH  scan word
- scan_idx  out  WA  word index: main chars first, then status chars
- scan_last  out  1  marks the final word (index MAIN_CHARS+STATUS_CHARS-1)

## Operation
- Storage is a flat array of NUM_REGS×WPR words.
  - Address = {reg, word}.
  - Main char c maps to word c.
  - Status index s maps to word MAIN_CHARS+s.
- Control FSM states: CLEAR, IDLE.
  - poc forces CLEAR with sweep counter 0.
  - CLEAR writes 0 to one word per cycle, only words with word < MAIN_CHARS+STATUS_CHARS and reg < NUM_REGS. It takes exactly NUM_REGS×(MAIN_CHARS+STATUS_CHARS) cycles, then goes to IDLE.
  - busy=1 and cmd_ready=0 in CLEAR. cmd_ready=1 in IDLE.
- Address latch (reg_q, char_q) is set by SRC.
- Commands:
  - WRM writes cmd_data to {reg_q, char_q}.
  - RDM reads {reg_q, char_q}.
  - WRS writes to {reg_q, MAIN_CHARS+cmd_sidx}.
  - RDS reads {reg_q, MAIN_CHARS+cmd_sidx}.
- Out-of-range targets (reg_q ≥ NUM_REGS, char_q ≥ MAIN_CHARS, or sidx ≥ STATUS_CHARS):
  - Writes are dropped.
  - Reads return 0, with rd_valid still pulsed.
- Scan FSM states: S_IDLE, S_LOAD, S_OUT.
  - S_IDLE: scan_start is accepted only when busy=0. Latch scan_reg, set idx=0, go to S_LOAD. scan_start outside S_IDLE is ignored.
  - S_LOAD: read word idx via the second read port into scan_data, set scan_valid=1, go to S_OUT.
  - S_OUT: hold data, idx and last while scan_ready=0. On handshake: if last, scan_valid=0 and go to S_IDLE; otherwise idx+1 and go to S_LOAD.
  - Net cost is 2 cycles per word. No wrap past the last word.
- An out-of-range scan_reg produces a full-length stream of zeros.

## Timing
- Reset values:
  - busy=1, cmd_ready=0, rd_valid=0, rd_data=0
  - scan_valid=0, scan_data=0, scan_idx=0, scan_last=0
  - reg_q=0, char_q=0, scan FSM in S_IDLE
- Write latency: the write commits on the accepting edge. An RDM on the next cycle to the same address returns the new value.
- Read latency: rd_valid and rd_data assert on the edge after acceptance, for one cycle. Back-to-back reads give back-to-back pulses.
- SRC followed immediately by RDM uses the new latch.
- Simultaneous WRM/WRS and scan S_LOAD to the same word: the scan captures the pre-write value.
- poc asserted mid-scan or mid-clear:
  - Outputs go immediately to reset values.
  - The scan is aborted.
  - The clear sweep restarts from word 0.

## Structure
- Package mcs4_pkg holds:
  - the cmd_op encodings (OP_NOP, OP_SRC, OP_WRM, OP_RDM, OP_WRS, OP_RDS)
  - the control and scan state encodings
  - a clog2 helper function
- One sub-module, mcs4_ram_dp:
  - DATA_WIDTH×DEPTH distributed RAM
  - one synchronous write port with combinational read
  - a second combinational read port
- The control FSM, scanner and address mapping live in mcs4_ram_bank.

## Test plan
- Post-reset clear (defaults): poc pulse → busy=1 and cmd_ready=0 for exactly 80 cycles, then every RDM/RDS in all 4 registers returns 0.
- Main R/W: SRC reg=2 char=5; WRM 0xA; RDM → rd_valid next cycle with rd_data=0xA. RDM at reg=2 char=6 → 0x0.
- Status R/W: SRC reg=3; WRS sidx=3 data 0x7; RDS sidx=3 → 0x7. RDM of char 3 in reg 3 is unaffected (0x0).
- Scan with backpressure:
  - Setup: reg 1 chars 0–15 loaded with values 0–15, status 0–3 loaded with 0x1–0x4.
  - Stimulus: scan_start with scan_reg=1, scan_ready toggling randomly.
  - Required: exactly 20 words in idx order, data/idx stable while stalled, scan_last only on idx 19.
- Write/scan collision: WRM to the word being loaded in the same cycle → scan shows the old value, a later RDM shows the new value.
- Reset mid-operation: poc during scan word 7 → scan_valid=0 immediately, busy=1, a full 80-cycle clear follows, no further scan words appear.
